// File: rtl/baudgen_frac.sv
// baudgen_frac: fractional baud-rate generator producing a one-cycle Rx
// oversample tick (Rxclk_en) and a one-cycle Tx bit tick (Txclk_en).
//
// Each Rx interval lasts D+c enabled clocks, where D = max(div_int,1) and c is
// the carry out of a FRAC_W-bit phase accumulator that adds div_frac once per
// Rx tick. Every OVERSAMPLE-th Rx tick is also a Tx tick.
//
// Divisor updates use a valid/ready handshake. An accepted value waits as
// pending and is switched in on a Tx boundary, so a bit in flight always
// finishes with the divisor it started with. When the generator is disabled,
// the pending value is switched in on the next clock instead.
//
// Build option: define BAUDGEN_FRAC_FRAC_EN to build the fractional
// accumulator. Without it c is always 0, cfg_div_frac is ignored and the
// reset fractional divisor is 0.
//
// Update handshake states:
//   state   | meaning
//   ST_IDLE | no update pending, cfg_ready=1
//   ST_PEND | update latched, waiting for a Tx boundary (or en=0) to apply

module baudgen_frac #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_ready,
  output logic              Rxclk_en,
  output logic              Txclk_en
);

  // The base counter is one bit wider than the divisor so that D+1 fits.
  localparam int unsigned CNT_W  = DIV_W + 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  // Reset divisor, derived from the clock and baud parameters.
  localparam longint unsigned TICK_HZ = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint unsigned DEF_INT_L = longint'(CLK_HZ) / TICK_HZ;
  localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DEF_INT_L);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              take;
  logic              apply;
  logic              carry;
  logic              rx_hit;
  logic              tx_hit;
  logic              rx_q;
  logic              tx_q;
  logic [DIV_W-1:0]  div_int_q;
  logic [DIV_W-1:0]  pend_int_q;
  logic [DIV_W-1:0]  div_eff;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  target;
  logic [TICK_W-1:0] tick_q;

`ifdef BAUDGEN_FRAC_FRAC_EN
  // Remainder scaled by 2^FRAC_W, rounded to nearest (half rounds up) and
  // saturated so that a remainder just under 1 cannot wrap to 0.
  localparam longint unsigned DEF_REM   = longint'(CLK_HZ) - DEF_INT_L * TICK_HZ;
  localparam longint unsigned FRAC_ONE  = 64'(1) << FRAC_W;
  localparam longint unsigned FRAC_RND  = ((DEF_REM << FRAC_W) * 2 + TICK_HZ) / (2 * TICK_HZ);
  localparam longint unsigned FRAC_SAT  = (FRAC_RND >= FRAC_ONE) ? (FRAC_ONE - 1) : FRAC_RND;
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(FRAC_SAT);

  logic [FRAC_W-1:0] div_frac_q;
  logic [FRAC_W-1:0] pend_frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   acc_sum;

  // The carry of this tick's accumulation stretches the current interval.
  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
  assign carry   = acc_sum[FRAC_W];
`else
  logic unused_frac;

  assign unused_frac = ^cfg_div_frac;
  assign carry       = 1'b0;
`endif

  assign take    = cfg_valid && cfg_ready;
  assign div_eff = (div_int_q == '0) ? DIV_W'(1) : div_int_q;
  assign target  = {1'b0, div_eff} + CNT_W'(carry);
  assign rx_hit  = ((cnt_q + CNT_W'(1)) == target);
  assign tx_hit  = rx_hit && (tick_q == TICK_W'(OVERSAMPLE - 1));

  assign Rxclk_en = rx_q;
  assign Txclk_en = tx_q;

  // Handshake state register.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state; apply fires on the visible Tx tick, or at once
  // when the generator is disabled.
  always_comb begin
    state_d   = state_q;
    apply     = 1'b0;
    cfg_ready = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en || tx_q) begin
          apply   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the offered integer divisor on a transfer.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      pend_int_q <= '0;
    end else if (take) begin
      pend_int_q <= cfg_div_int;
    end
  end

  // Base counter, tick counter, registered ticks and active integer divisor.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      div_int_q <= DEF_INT;
      cnt_q     <= '0;
      tick_q    <= '0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
    end else if (apply) begin
      div_int_q <= pend_int_q;
      cnt_q     <= '0;
      tick_q    <= '0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
    end else if (en) begin
      rx_q <= rx_hit;
      tx_q <= tx_hit;
      if (rx_hit) begin
        cnt_q  <= '0;
        tick_q <= tx_hit ? '0 : (tick_q + TICK_W'(1));
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      rx_q <= 1'b0;
      tx_q <= 1'b0;
    end
  end

`ifdef BAUDGEN_FRAC_FRAC_EN
  // Latch the offered fractional divisor on a transfer.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      pend_frac_q <= '0;
    end else if (take) begin
      pend_frac_q <= cfg_div_frac;
    end
  end

  // Phase accumulator (wraps modulo 2^FRAC_W) and active fractional divisor.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      div_frac_q <= DEF_FRAC;
      acc_q      <= '0;
    end else if (apply) begin
      div_frac_q <= pend_frac_q;
      acc_q      <= '0;
    end else if (en && rx_hit) begin
      acc_q <= acc_sum[FRAC_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_baudgen_frac.sv
// Directed bench for baudgen_frac: expected tick times are derived from the
// divisor arithmetic and queued as stimulus is driven, then compared with the
// tick times captured from the DUT.
module tb_baudgen_frac;

`ifdef BAUDGEN_FRAC_FRAC_EN
  localparam int DEF_FRAC = 2;
  localparam longint DEF_TXP = 434;
`else
  localparam int DEF_FRAC = 0;
  localparam longint DEF_TXP = 432;
`endif
  localparam int DEF_INT = 27;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        cfg_ready;
  logic        Rxclk_en;
  logic        Txclk_en;

  baudgen_frac dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_ready    (cfg_ready),
    .Rxclk_en     (Rxclk_en),
    .Txclk_en     (Txclk_en)
  );

  always #5 clk_50m = ~clk_50m;

  longint cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  longint obs_rx[$];
  longint obs_tx[$];
  longint exp_rx[$];
  longint exp_tx[$];
  int total = 0;
  int bad = 0;

  always @(negedge clk_50m) begin
    if (Rxclk_en === 1'b1) obs_rx.push_back(cyc);
    if (Txclk_en === 1'b1) obs_tx.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic wait_cyc(input longint c);
    while (cyc < c) @(negedge clk_50m);
  endtask

  // Queue the tick times expected from 'start' (first enabled cycle): each
  // interval is max(d,1)+carry enabled cycles, every 16th tick is a Tx tick.
  // An en=0 gap of gap_len cycles starts gap_off cycles after tick gap_after.
  task automatic gen(input longint start, input int d, input int fr, input int np,
                     input int gap_after, input int gap_off, input int gap_len,
                     output longint gs);
    longint t = start;
    int n = 0;
    int k = 0;
    int acc = 0;
    int de = (d == 0) ? 1 : d;
    int l;
    bit in_gap;
    gs = -1;
    while (k < np) begin
      l = de + (((acc + fr) >= 16) ? 1 : 0);
      in_gap = (gs >= 0) && (t >= gs) && (t < gs + gap_len);
      if (!in_gap) n++;
      if (n == l) begin
        exp_rx.push_back(t + 1);
        if ((k % 16) == 15) exp_tx.push_back(t + 1);
        if (k == gap_after) gs = t + 1 + gap_off;
        acc = (acc + fr) % 16;
        n = 0;
        k++;
      end
      t++;
    end
  endtask

  task automatic flush(input string tag);
    longint lim;
    longint o;
    lim = exp_rx.size() > 0 ? exp_rx[$] : cyc;
    while (exp_rx.size() > 0) begin
      o = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
      chk({tag, " rx"}, o, exp_rx.pop_front());
    end
    while (obs_rx.size() > 0 && obs_rx[0] <= lim) chk({tag, " rx extra"}, obs_rx.pop_front(), -1);
    while (exp_tx.size() > 0) begin
      o = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
      chk({tag, " tx"}, o, exp_tx.pop_front());
    end
    while (obs_tx.size() > 0 && obs_tx[0] <= lim) chk({tag, " tx extra"}, obs_tx.pop_front(), -1);
    obs_rx.delete();
    obs_tx.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst = 1'b0;
    obs_rx.delete();
    obs_tx.delete();
    exp_rx.delete();
    exp_tx.delete();
  endtask

  initial begin
    longint e0, a0, t0, t1, gs, dummy;
    rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    cfg_div_int = '0;
    cfg_div_frac = '0;

    // Reset state, then default divisor with a 100-cycle en gap mid-interval.
    do_reset();
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset rx", Rxclk_en, 0);
    chk("reset tx", Txclk_en, 0);
    e0 = cyc + 2;
    wait_cyc(e0);
    en = 1'b1;
    gen(e0, DEF_INT, DEF_FRAC, 48, 34, 5, 100, gs);
    wait_cyc(gs);
    en = 1'b0;
    wait_cyc(gs + 100);
    en = 1'b1;
    wait_cyc(exp_rx[$] + 2);
    chk("first rx latency", (obs_rx.size() > 0) ? obs_rx[0] - e0 : -1, DEF_INT);
    chk("default tx period", (obs_tx.size() > 1) ? obs_tx[1] - obs_tx[0] : -1, DEF_TXP);
    flush("default");

    // Divisor 4/0 accepted mid-bit: applied at the next Tx tick.
    do_reset();
    e0 = cyc + 2;
    wait_cyc(e0);
    en = 1'b1;
    gen(e0, DEF_INT, DEF_FRAC, 16, -1, 0, 0, dummy);
    t0 = exp_tx[0];
    gen(t0 + 1, 4, 0, 40, -1, 0, 0, dummy);
    a0 = e0 + 100;
    wait_cyc(a0);
    cfg_div_int = 16'd4;
    cfg_div_frac = 4'd0;
    cfg_valid = 1'b1;
    chk("upd ready at offer", cfg_ready, 1);
    wait_cyc(a0 + 1);
    cfg_valid = 1'b0;
    chk("upd ready after accept", cfg_ready, 0);
    wait_cyc(t0);
    chk("upd ready at tx", cfg_ready, 0);
    wait_cyc(t0 + 1);
    chk("upd ready after apply", cfg_ready, 1);
    wait_cyc(exp_rx[$] + 2);
    chk("upd rx period", (obs_rx.size() > 1) ? obs_rx[obs_rx.size()-1] - obs_rx[obs_rx.size()-2] : -1, 4);
    chk("upd tx period", (obs_tx.size() > 2) ? obs_tx[2] - obs_tx[1] : -1, 64);
    flush("upd mid");

    // Divisor offered in the very cycle of a Tx tick: applied one bit later.
    do_reset();
    e0 = cyc + 2;
    wait_cyc(e0);
    en = 1'b1;
    gen(e0, DEF_INT, DEF_FRAC, 32, -1, 0, 0, dummy);
    t0 = exp_tx[0];
    t1 = exp_tx[1];
    gen(t1 + 1, 4, 0, 20, -1, 0, 0, dummy);
    wait_cyc(t0);
    cfg_div_int = 16'd4;
    cfg_div_frac = 4'd0;
    cfg_valid = 1'b1;
    chk("edge ready at offer", cfg_ready, 1);
    wait_cyc(t0 + 1);
    cfg_valid = 1'b0;
    wait_cyc(t1);
    chk("edge ready at next tx", cfg_ready, 0);
    wait_cyc(t1 + 1);
    chk("edge ready after apply", cfg_ready, 1);
    wait_cyc(exp_rx[$] + 2);
    flush("upd edge");

    // Divisor 0/0 while disabled: applied the cycle after acceptance, then a
    // tick every cycle.
    do_reset();
    a0 = cyc + 2;
    wait_cyc(a0);
    cfg_div_int = 16'd0;
    cfg_div_frac = 4'd0;
    cfg_valid = 1'b1;
    chk("div0 ready at offer", cfg_ready, 1);
    wait_cyc(a0 + 1);
    cfg_valid = 1'b0;
    chk("div0 ready pending", cfg_ready, 0);
    wait_cyc(a0 + 2);
    chk("div0 ready applied", cfg_ready, 1);
    e0 = a0 + 5;
    wait_cyc(e0);
    en = 1'b1;
    gen(e0, 0, 0, 40, -1, 0, 0, dummy);
    wait_cyc(exp_rx[$] + 2);
    chk("div0 tx period", (obs_tx.size() > 1) ? obs_tx[1] - obs_tx[0] : -1, 16);
    flush("div0");

    // Reset while an update is pending: defaults return, update is lost.
    do_reset();
    e0 = cyc + 2;
    wait_cyc(e0);
    en = 1'b1;
    wait_cyc(e0 + 50);
    cfg_div_int = 16'd4;
    cfg_div_frac = 4'd0;
    cfg_valid = 1'b1;
    wait_cyc(e0 + 51);
    cfg_valid = 1'b0;
    chk("rstpend ready pending", cfg_ready, 0);
    wait_cyc(e0 + 60);
    rst = 1'b1;
    wait_cyc(e0 + 61);
    rst = 1'b0;
    chk("rstpend cfg_ready", cfg_ready, 1);
    chk("rstpend rx", Rxclk_en, 0);
    chk("rstpend tx", Txclk_en, 0);
    obs_rx.delete();
    obs_tx.delete();
    gen(e0 + 61, DEF_INT, DEF_FRAC, 20, -1, 0, 0, dummy);
    wait_cyc(exp_rx[$] + 2);
    flush("rstpend");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
